// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if -- operand/handshake bundle for the universal shift register.
//   master : datapath controller (drives load/start/operands, watches results)
//   slave  : univ_shift_reg
// Signals
//   load, data_in           parallel load request and value
//   start, op, amount       shift request, operation code, step count
//   serial_in               fill bit for SLL/SRL
//   shift_out, serial_out   register contents, last expelled bit
//   busy, done              operation in progress, completion pulse
interface univ_shift_reg_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] amount;
  logic             serial_in;
  logic [WIDTH-1:0] shift_out;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output load, data_in, start, op, amount, serial_in,
    input  shift_out, serial_out, busy, done
  );

  modport slave (
    input  load, data_in, start, op, amount, serial_in,
    output shift_out, serial_out, busy, done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg -- parametrised universal shift register (load, SLL, SRL, SRA,
// ROL, ROR) driven by a start/busy/done handshake.
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears register, serial_out, busy, done
//   sr     univ_shift_reg_if.slave: load/data_in, start/op/amount/serial_in in;
//          shift_out/serial_out/busy/done out (all registered)
// Build option
//   USHIFT_BARREL_EN  defined: a non-zero operation finishes in one RUN cycle
//                     through a barrel network (bit-identical to stepping).
//                     undefined: one 1-bit step per RUN cycle.
//
// state | meaning
// IDLE  | accepts load / start; done pulses here after a finished operation
// RUN   | operation in progress, busy=1
module univ_shift_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic              clk,
  input logic              reset,
  univ_shift_reg_if.slave  sr
);

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] reg_q;
  logic             sout_q;
  logic             busy_q;
  logic             done_q;
  logic [2:0]       op_q;
  logic             fill_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] nxt_val;
  logic             nxt_out;
  logic             run_last;

`ifdef USHIFT_BARREL_EN
  localparam int IW = $clog2(WIDTH);

  // Closed-form equivalent of stepping amt times. Shifts past WIDTH saturate
  // to the fill bit; rotates reduce modulo WIDTH, and the last expelled bit of
  // a rotate is the bit that wrapped into the opposite end.
  function automatic logic [WIDTH:0] barrel(
    input logic [WIDTH-1:0] r,
    input logic [2:0]       op,
    input logic [CNT_W-1:0] amt,
    input logic             fill
  );
    int               a;
    int               m;
    int               src;
    logic [WIDTH-1:0] v;
    logic             o;
    logic             f;
    a   = int'(amt);
    m   = a % WIDTH;
    v   = r;
    o   = fill;
    src = 0;
    f   = (op == OP_SRA) ? r[WIDTH-1] : fill;
    case (op)
      OP_SLL: begin
        for (int i = 0; i < WIDTH; i++) begin
          src  = i - a;
          v[i] = (src >= 0) ? r[IW'(src)] : f;
        end
        o = (a <= WIDTH) ? r[IW'(WIDTH - a)] : f;
      end
      OP_SRL, OP_SRA: begin
        for (int i = 0; i < WIDTH; i++) begin
          src  = i + a;
          v[i] = (src < WIDTH) ? r[IW'(src)] : f;
        end
        o = (a >= 1 && a <= WIDTH) ? r[IW'(a - 1)] : f;
      end
      OP_ROL: begin
        for (int i = 0; i < WIDTH; i++) begin
          src  = (i - m + WIDTH) % WIDTH;
          v[i] = r[IW'(src)];
        end
        o = v[0];
      end
      OP_ROR: begin
        for (int i = 0; i < WIDTH; i++) begin
          src  = (i + m) % WIDTH;
          v[i] = r[IW'(src)];
        end
        o = v[WIDTH-1];
      end
      default: begin
        v = r;
        o = fill;
      end
    endcase
    return {o, v};
  endfunction

  always_comb begin
    {nxt_out, nxt_val} = barrel(reg_q, op_q, cnt_q, fill_q);
    run_last           = 1'b1;
  end
`else
  always_comb begin
    nxt_val  = reg_q;
    nxt_out  = sout_q;
    run_last = (cnt_q == CNT_W'(1));
    case (op_q)
      OP_SLL: begin
        nxt_val = {reg_q[WIDTH-2:0], fill_q};
        nxt_out = reg_q[WIDTH-1];
      end
      OP_SRL: begin
        nxt_val = {fill_q, reg_q[WIDTH-1:1]};
        nxt_out = reg_q[0];
      end
      OP_SRA: begin
        nxt_val = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
        nxt_out = reg_q[0];
      end
      OP_ROL: begin
        nxt_val = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
        nxt_out = reg_q[WIDTH-1];
      end
      OP_ROR: begin
        nxt_val = {reg_q[0], reg_q[WIDTH-1:1]};
        nxt_out = reg_q[0];
      end
      default: begin
        nxt_val = reg_q;
        nxt_out = sout_q;
      end
    endcase
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      reg_q   <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= OP_SLL;
      fill_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (sr.load) begin
            // load wins over a simultaneous start; that start is dropped
            reg_q  <= sr.data_in;
            sout_q <= 1'b0;
          end else if (sr.start) begin
            op_q   <= sr.op;
            fill_q <= sr.serial_in;
            cnt_q  <= sr.amount;
            if (sr.amount == '0 || sr.op > OP_ROR) begin
              done_q <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          reg_q  <= nxt_val;
          sout_q <= nxt_out;
          if (run_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sr.shift_out  = reg_q;
  assign sr.serial_out = sout_q;
  assign sr.busy       = busy_q;
  assign sr.done       = done_q;

endmodule
